hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

- Per-core pipeline controller; the source of the enable and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Every pipeline register loads only when its enable is high, and honours flush only when flush and enable are high together.
- This unit therefore holds a pending flush until an advancing cycle consumes it.
- It detects load-use hazards, cache-miss stalls, EX-stage redirects and halt retirement, and counts stall cycles.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmem_req_MEM  in  1  MEM stage holds a load, store or atomic
- MemRead_EX  in  1  EX stage holds a load
- wsel_EX  in  5  EX destination register
- rs1_ID, rs2_ID  in  5 each  ID source registers
- use_rs1_ID, use_rs2_ID  in  1 each  source actually read
- redirect_EX  in  1  taken branch or jump resolved in EX
- is_halt_MEM, is_halt_WB  in  1 each  halt instruction in that stage
- pc_en  out  1  PC update enable
- en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB  out  1 each  register enables
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  bubble insert (effective with enable)
- pc_redirect  out  1  PC takes EX target this cycle
- halt  out  1  core halted, sticky
- stall_count  out  CNT_W  saturating count of non-advancing cycles

## Operation
State machine states:
- RUN: normal operation.
- DRAIN: halt is in MEM; waiting for it to reach WB.
- HALTED: terminal; exits only by reset.

State transitions:
- RUN -> DRAIN when is_halt_MEM && adv.
- DRAIN -> HALTED when is_halt_WB && adv.
- HALTED persists until nRST.

Advance signal:
- adv = ihit && (!dmem_req_MEM || dhit).
- When adv = 0, every enable is 0 and flushes keep their values; no register moves.

RUN, adv = 1, in priority order:
1. Redirect: taken when redirect_EX or redirect_pending is set.
   - All enables = 1, pc_redirect = 1.
   - flush_IF_ID = flush_ID_EX = 1 (both instructions are wrong-path).
   - Load-use is suppressed.
2. Load-use: MemRead_EX && wsel_EX != 0 && ((use_rs1_ID && rs1_ID == wsel_EX) || (use_rs2_ID && rs2_ID == wsel_EX)).
   - pc_en = en_IF_ID = 0.
   - en_ID_EX = 1 with flush_ID_EX = 1 (bubble).
   - en_EX_MEM = en_MEM_WB = 1.
3. Otherwise all enables = 1 and all flushes = 0.

Redirect pending flop:
- Set when redirect_EX && !adv.
- Cleared on the first adv cycle in which the redirect is taken.
- pc_redirect is never asserted in a non-advancing cycle.

DRAIN:
- pc_en = en_IF_ID = 0.
- en_ID_EX, en_EX_MEM, en_MEM_WB = adv.
- flush_ID_EX = flush_EX_MEM = 1, so nothing younger than the halt enters MEM.
- Redirects are ignored and redirect_pending is cleared.

HALTED:
- All enables 0, all flushes 0, halt = 1.

stall_count:
- Increments in RUN/DRAIN cycles where adv = 0 or a load-use bubble is inserted.
- Saturates at 2^CNT_W-1.
- Frozen in HALTED.

## Timing
Reset values:
- State RUN; redirect_pending, halt and stall_count all 0.
- While nRST is low, all enables and flushes are 0.

Output timing:
- Enables, flushes and pc_redirect are combinational (Mealy) from the current state and inputs, valid in the same cycle.
- halt and stall_count are registered; they update at the posedge following the triggering cycle.

Latencies:
- Load-use costs exactly 1 bubble cycle, plus any miss cycles.
- A redirect that arrives during a stall is applied in the first cycle with adv = 1.

Corner cases:
- redirect_EX together with load-use: the redirect wins, and no bubble count is taken.
- is_halt_MEM together with redirect_EX: the transition to DRAIN wins.
- wsel_EX = 0 never creates a hazard.
- Reset asserted mid-stall or mid-DRAIN returns to RUN immediately and drops the pending flush.

## Structure
Shared in cpu_types_pkg:
- ctrl_state_t enum {RUN, DRAIN, HALTED}.
- The regbits_t and word_t types already used there.

Sub-modules:
- One natural sub-module, hazard_detect: purely combinational load-use comparator.
- The FSM, pending flop and counter stay in hazard_ctrl_unit.

## Test plan
1. Load-use:
   - Stimulus: ihit = 1, no dmem request; MemRead_EX = 1, wsel_EX = 5, rs2_ID = 5, use_rs2_ID = 1.
   - Required response: pc_en = 0, en_IF_ID = 0, en_ID_EX = 1, flush_ID_EX = 1; stall_count goes 0 -> 1.
   - Repeat with wsel_EX = 0: no stall.
2. Miss stall:
   - Stimulus: dmem_req_MEM = 1, dhit = 0 for 3 cycles, then dhit = 1.
   - Required response: all enables 0 for 3 cycles, then all 1; stall_count = 3.
3. Redirect during a miss:
   - Stimulus: redirect_EX pulses for 1 cycle while ihit = 0; ihit rises 2 cycles later.
   - Required response: pc_redirect, flush_IF_ID and flush_ID_EX assert only in the ihit cycle, then clear.
4. Redirect with load-use:
   - Stimulus: redirect_EX = 1 in the same cycle as a load-use match.
   - Required response: pc_en = 1, flush_IF_ID = flush_ID_EX = 1; stall_count unchanged.
5. Halt:
   - Stimulus: is_halt_MEM with adv = 1, then is_halt_WB next cycle.
   - Required response: DRAIN for 1 cycle with pc_en = 0; halt = 1 after the following posedge; all enables 0 thereafter, even with ihit = 1.
6. Reset in DRAIN:
   - Stimulus: nRST pulsed low while in DRAIN with redirect_pending set.
   - Required response: halt = 0, stall_count = 0, state RUN; no pc_redirect after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types and pipeline-control state encoding
// Purpose: common register/word types and the hazard-controller FSM encoding.
// Contents: regbits_t, word_t, ctrl_state_t, ST_* state constants.
package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Plain-vector view of the same encoding for modules that keep state in logic.
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_DRAIN  = DRAIN;
  localparam logic [1:0] ST_HALTED = HALTED;

endpackage

// File: rtl/hazard_ctrl_unit_hazard_detect.sv
// rtl/hazard_ctrl_unit_hazard_detect.sv - combinational load-use hazard comparator
// Purpose: flags when the ID-stage instruction reads the register a load in EX
//          is about to write.
// Ports:
//   MemRead_EX          in  EX stage holds a load
//   wsel_EX             in  EX destination register
//   rs1_ID, rs2_ID      in  ID source registers
//   use_rs1_ID/rs2_ID   in  source actually read
//   load_use            out hazard present
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     MemRead_EX,
  input  regbits_t wsel_EX,
  input  regbits_t rs1_ID,
  input  regbits_t rs2_ID,
  input  logic     use_rs1_ID,
  input  logic     use_rs2_ID,
  output logic     load_use
);

  logic match_rs1;
  logic match_rs2;

  assign match_rs1 = use_rs1_ID && (rs1_ID == wsel_EX);
  assign match_rs2 = use_rs2_ID && (rs2_ID == wsel_EX);

  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for.
  assign load_use = MemRead_EX && (wsel_EX != 5'd0) && (match_rs1 || match_rs2);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - per-core pipeline enable/flush controller
// Purpose: drives the enables and flushes of the IF/ID, ID/EX, EX/MEM and
//          MEM/WB registers; handles load-use, cache-miss stalls, EX redirects
//          and halt retirement; counts stall cycles.
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   ihit, dhit, dmem_req_MEM          memory handshake inputs (form adv)
//   MemRead_EX, wsel_EX, rs*_ID,
//   use_rs*_ID                        load-use detection inputs
//   redirect_EX                       taken branch/jump resolved in EX
//   is_halt_MEM, is_halt_WB           halt position in the pipe
//   pc_en, en_*                       register enables (combinational)
//   flush_*                           bubble inserts, effective with enable
//   pc_redirect                       PC loads the EX target this cycle
//   halt                              sticky core-halted flag (registered)
//   stall_count                       saturating non-advancing cycle count
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_MEM,
  input  logic             MemRead_EX,
  input  logic [4:0]       wsel_EX,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             redirect_EX,
  input  logic             is_halt_MEM,
  input  logic             is_halt_WB,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             pc_redirect,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       redirect_pending;
  logic       pending_nxt;
  logic       adv;
  logic       load_use;
  logic       take_redirect;
  logic       bubble;
  logic       count_evt;

  hazard_detect u_hazard_detect (
    .MemRead_EX (MemRead_EX),
    .wsel_EX    (wsel_EX),
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .use_rs1_ID (use_rs1_ID),
    .use_rs2_ID (use_rs2_ID),
    .load_use   (load_use)
  );

  assign adv = ihit && (!dmem_req_MEM || dhit);

  // A halt leaving MEM outranks any redirect: the redirecting instruction is
  // younger than the halt and must not steer the PC.
  assign take_redirect = (redirect_EX || redirect_pending) && !is_halt_MEM;
  assign bubble        = (state == ST_RUN) && adv && !take_redirect && load_use;
  assign count_evt     = ((state == ST_RUN) || (state == ST_DRAIN)) && (!adv || bubble);

  always_comb begin
    pc_en        = 1'b0;
    en_IF_ID     = 1'b0;
    en_ID_EX     = 1'b0;
    en_EX_MEM    = 1'b0;
    en_MEM_WB    = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    pc_redirect  = 1'b0;
    if (nRST) begin
      case (state)
        ST_RUN: begin
          if (adv) begin
            en_ID_EX  = 1'b1;
            en_EX_MEM = 1'b1;
            en_MEM_WB = 1'b1;
            if (take_redirect) begin
              pc_en       = 1'b1;
              en_IF_ID    = 1'b1;
              flush_IF_ID = 1'b1;
              flush_ID_EX = 1'b1;
              pc_redirect = 1'b1;
            end else if (load_use) begin
              // Hold PC and IF/ID; push a bubble into EX.
              flush_ID_EX = 1'b1;
            end else begin
              pc_en    = 1'b1;
              en_IF_ID = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Only the halt and older instructions may proceed to WB.
          en_ID_EX     = adv;
          en_EX_MEM    = adv;
          en_MEM_WB    = adv;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = 1'b0;
    case (state)
      ST_RUN: begin
        if (!adv)
          pending_nxt = redirect_pending || redirect_EX;
        else if (take_redirect)
          pending_nxt = 1'b0;
        else
          pending_nxt = redirect_pending;
        if (is_halt_MEM && adv)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (is_halt_WB && adv)
          state_nxt = ST_HALTED;
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state            <= ST_RUN;
      redirect_pending <= 1'b0;
      halt             <= 1'b0;
      stall_count      <= '0;
    end else begin
      state            <= state_nxt;
      redirect_pending <= pending_nxt;
      if ((state == ST_DRAIN) && is_halt_WB && adv)
        halt <= 1'b1;
      if (count_evt && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  localparam int CW = 4;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, dmem_req_MEM, MemRead_EX;
  logic [4:0] wsel_EX, rs1_ID, rs2_ID;
  logic use_rs1_ID, use_rs2_ID, redirect_EX, is_halt_MEM, is_halt_WB;
  logic pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_redirect, halt;
  logic [CW-1:0] stall_count;

  int tests = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req_MEM(dmem_req_MEM),
    .MemRead_EX(MemRead_EX), .wsel_EX(wsel_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .redirect_EX(redirect_EX),
    .is_halt_MEM(is_halt_MEM), .is_halt_WB(is_halt_WB), .pc_en(pc_en),
    .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .pc_redirect(pc_redirect), .halt(halt), .stall_count(stall_count)
  );

  // {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_redirect}
  wire [8:0] ctl = {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
                    flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_redirect};

  localparam logic [8:0] NONE   = 9'b00000_000_0;
  localparam logic [8:0] ALL    = 9'b11111_000_0;
  localparam logic [8:0] LU     = 9'b00111_010_0;
  localparam logic [8:0] RDR    = 9'b11111_110_1;
  localparam logic [8:0] DRN_A  = 9'b00111_011_0;
  localparam logic [8:0] DRN_S  = 9'b00000_011_0;

  typedef struct packed {
    logic ihit, dhit, dreq, mr;
    logic [4:0] wsel, rs1, rs2;
    logic u1, u2, rdr, hm, hw;
  } stim_t;

  typedef struct packed {
    logic [8:0]    ctl;
    logic [CW-1:0] cnt;
    logic          hlt;
  } exp_t;

  exp_t sb[$];

  function automatic stim_t mk(logic ih, logic dh, logic dr, logic mr, logic [4:0] ws,
                               logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
                               logic rd, logic hm, logic hw);
    stim_t s;
    s = '{ih, dh, dr, mr, ws, r1, r2, u1, u2, rd, hm, hw};
    return s;
  endfunction

  function automatic exp_t ex(logic [8:0] c, int n, logic h);
    exp_t e;
    e.ctl = c;
    e.cnt = n[CW-1:0];
    e.hlt = h;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    ihit = s.ihit; dhit = s.dhit; dmem_req_MEM = s.dreq; MemRead_EX = s.mr;
    wsel_EX = s.wsel; rs1_ID = s.rs1; rs2_ID = s.rs2;
    use_rs1_ID = s.u1; use_rs2_ID = s.u2; redirect_EX = s.rdr;
    is_halt_MEM = s.hm; is_halt_WB = s.hw;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    nRST = 1'b0;
    apply(mk(1,0,0,0,0,0,0,0,0,0,0,0));
    sb.push_back(ex(NONE, 0, 0));
    @(negedge CLK);
    e = sb.pop_front();
    tests++;
    if ({ctl, stall_count, halt} !== e) begin
      failed++;
      $display("FAIL reset: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
               ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
    end
    next_cycle();
    nRST = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t s[6];
    exp_t  x[6];
    exp_t  e;
    s = '{mk(1,0,0,1,5,3,5,1,1,0,0,0), mk(1,0,0,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,1,0,0,0,1,1,0,0,0), mk(1,0,0,1,7,7,2,1,0,0,0,0),
          mk(1,0,0,1,7,7,2,0,1,0,0,0), mk(1,0,0,0,0,0,0,0,0,0,0,0)};
    x = '{ex(LU,0,0), ex(ALL,1,0), ex(ALL,1,0), ex(LU,1,0), ex(ALL,2,0), ex(ALL,2,0)};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL load_use[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      next_cycle();
    end
  endtask

  task automatic test_miss();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    s = '{mk(1,0,1,0,0,0,0,0,0,0,0,0), mk(1,0,1,0,0,0,0,0,0,0,0,0),
          mk(1,0,1,0,0,0,0,0,0,0,0,0), mk(1,1,1,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,0,0,0,0,0,0,0,0,0)};
    x = '{ex(NONE,2,0), ex(NONE,3,0), ex(NONE,4,0), ex(ALL,5,0), ex(ALL,5,0)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL miss[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_miss();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    s = '{mk(0,0,0,0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,0,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,0,0,0,0,0,0,0,0,0)};
    x = '{ex(NONE,5,0), ex(NONE,6,0), ex(RDR,7,0), ex(ALL,7,0), ex(ALL,7,0)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL redirect_miss[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_load_use();
    stim_t s[3];
    exp_t  x[3];
    exp_t  e;
    s = '{mk(1,0,0,1,5,0,5,0,1,1,0,0), mk(1,0,0,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,0,0,0,0,0,0,0,0,0)};
    x = '{ex(RDR,7,0), ex(ALL,7,0), ex(ALL,7,0)};
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL redirect_load_use[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    s = '{mk(1,0,0,0,0,0,0,0,0,0,1,0), mk(1,0,0,0,0,0,0,0,0,0,0,1),
          mk(1,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,1,5,5,0,1,0,1,0,0)};
    x = '{ex(ALL,7,0), ex(DRN_A,7,0), ex(NONE,7,1), ex(NONE,7,1), ex(NONE,7,1)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL halt[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      next_cycle();
    end
  endtask

  // Stall with a redirect (pending set), enter DRAIN, reset before the pending
  // flop can be cleared by DRAIN itself.
  task automatic test_reset_in_drain();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1;
    s = '{mk(0,0,0,0,0,0,0,0,0,1,0,0), mk(1,0,0,0,0,0,0,0,0,0,1,0),
          mk(0,0,0,0,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0,0,0,0),
          mk(1,0,0,0,0,0,0,0,0,0,0,0)};
    x = '{ex(NONE,0,0), ex(ALL,1,0), ex(DRN_S,1,0), ex(ALL,0,0), ex(ALL,0,0)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL reset_in_drain[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      if (i == 2) begin
        #2;
        nRST = 1'b0;
        sb.push_back(ex(NONE, 0, 0));
        #1;
        e = sb.pop_front();
        tests++;
        if ({ctl, stall_count, halt} !== e) begin
          failed++;
          $display("FAIL reset_in_drain_async: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                   ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
        end
        next_cycle();
        nRST = 1'b1;
      end else begin
        next_cycle();
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int   model;
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1;
    model = 0;
    for (int i = 0; i < 19; i++) begin
      apply(mk(0,0,0,0,0,0,0,0,0,0,0,0));
      sb.push_back(ex(NONE, model, 0));
      @(negedge CLK);
      e = sb.pop_front();
      tests++;
      if ({ctl, stall_count, halt} !== e) begin
        failed++;
        $display("FAIL saturate[%0d]: ctl=%b cnt=%0d halt=%b want ctl=%b cnt=%0d halt=%b",
                 i, ctl, stall_count, halt, e.ctl, e.cnt, e.hlt);
      end
      if (model < (1 << CW) - 1)
        model++;
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_miss();
    test_redirect_miss();
    test_redirect_load_use();
    test_halt();
    test_reset_in_drain();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
